// File: rtl/wishbone_pkg.sv
// Shared types and constants for the two-master Wishbone bus arbiter.
package wishbone_pkg;

    localparam int unsigned WB_ADDR_WIDTH = 10;
    localparam int unsigned WB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_GRANT_M0 = 2'd1,
        ARB_GRANT_M1 = 2'd2
    } arb_state_e;

    localparam logic MASTER_M0 = 1'b0;
    localparam logic MASTER_M1 = 1'b1;

endpackage

// File: rtl/wishbone_arb_timeout.sv
// Bus-cycle watchdog: counts strobed cycles without a slave response and
// flags a timeout once TIMEOUT_CYCLES is reached.
module wishbone_arb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic grant_start,
    input  logic granted,
    input  logic bus_active,
    input  logic wb_ack,
    input  logic wb_err,
    output logic timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    // Saturates at LIMIT so the comparison stays true until the grant is dropped.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else if (grant_start || wb_ack || wb_err) begin
            cnt_q <= '0;
        end else if (bus_active && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout = granted && (cnt_q == LIMIT);

endmodule

// File: rtl/wishbone_bus_arbiter.sv
// Round-robin, cycle-locked arbiter sharing one Wishbone slave between two masters.
// Optional watchdog enabled with the WB_ARB_TIMEOUT_EN macro.
module wishbone_bus_arbiter
    import wishbone_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = WB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = WB_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_m0_cyc,
    input  logic                    i_m0_stb,
    input  logic                    i_m0_we,
    input  logic [ADDR_WIDTH-1:0]   i_m0_addr,
    input  logic [DATA_WIDTH-1:0]   i_m0_data,
    input  logic [DATA_WIDTH/8-1:0] i_m0_sel,
    input  logic                    i_m1_cyc,
    input  logic                    i_m1_stb,
    input  logic                    i_m1_we,
    input  logic [ADDR_WIDTH-1:0]   i_m1_addr,
    input  logic [DATA_WIDTH-1:0]   i_m1_data,
    input  logic [DATA_WIDTH/8-1:0] i_m1_sel,
    output logic                    o_m0_ack,
    output logic                    o_m0_stall,
    output logic                    o_m0_err,
    output logic [DATA_WIDTH-1:0]   o_m0_data,
    output logic                    o_m1_ack,
    output logic                    o_m1_stall,
    output logic                    o_m1_err,
    output logic [DATA_WIDTH-1:0]   o_m1_data,
    output logic                    o_wb_cyc,
    output logic                    o_wb_stb,
    output logic                    o_wb_we,
    output logic [ADDR_WIDTH-1:0]   o_wb_addr,
    output logic [DATA_WIDTH-1:0]   o_wb_data,
    output logic [DATA_WIDTH/8-1:0] o_wb_sel,
    input  logic                    i_wb_ack,
    input  logic                    i_wb_stall,
    input  logic                    i_wb_err,
    input  logic [DATA_WIDTH-1:0]   i_wb_data
);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e state_q, state_d;
    logic       last_grant_q;
    logic       timeout;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= MASTER_M1;
        end else begin
            state_q <= state_d;
            if (state_d == ARB_GRANT_M0) begin
                last_grant_q <= MASTER_M0;
            end else if (state_d == ARB_GRANT_M1) begin
                last_grant_q <= MASTER_M1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    state_d = (last_grant_q == MASTER_M0) ? ARB_GRANT_M1 : ARB_GRANT_M0;
                end else if (i_m0_cyc) begin
                    state_d = ARB_GRANT_M0;
                end else if (i_m1_cyc) begin
                    state_d = ARB_GRANT_M1;
                end
            end
            ARB_GRANT_M0: if (!i_m0_cyc) state_d = i_m1_cyc ? ARB_GRANT_M1 : ARB_IDLE;
            ARB_GRANT_M1: if (!i_m1_cyc) state_d = i_m0_cyc ? ARB_GRANT_M0 : ARB_IDLE;
            default:      state_d = ARB_IDLE;
        endcase
        if (timeout) state_d = ARB_IDLE;
    end

    // A timeout cycle still belongs to the granted master but drops the bus.
    always_comb begin
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        o_wb_we    = 1'b0;
        o_wb_addr  = '0;
        o_wb_data  = '0;
        o_wb_sel   = '0;
        o_m0_ack   = 1'b0;
        o_m0_err   = 1'b0;
        o_m0_stall = 1'b1;
        o_m1_ack   = 1'b0;
        o_m1_err   = 1'b0;
        o_m1_stall = 1'b1;
        case (state_q)
            ARB_GRANT_M0: begin
                o_wb_cyc   = i_m0_cyc & ~timeout;
                o_wb_stb   = i_m0_stb & ~timeout;
                o_wb_we    = i_m0_we;
                o_wb_addr  = i_m0_addr;
                o_wb_data  = i_m0_data;
                o_wb_sel   = i_m0_sel;
                o_m0_ack   = i_wb_ack;
                o_m0_err   = i_wb_err | timeout;
                o_m0_stall = i_wb_stall;
            end
            ARB_GRANT_M1: begin
                o_wb_cyc   = i_m1_cyc & ~timeout;
                o_wb_stb   = i_m1_stb & ~timeout;
                o_wb_we    = i_m1_we;
                o_wb_addr  = i_m1_addr;
                o_wb_data  = i_m1_data;
                o_wb_sel   = i_m1_sel;
                o_m1_ack   = i_wb_ack;
                o_m1_err   = i_wb_err | timeout;
                o_m1_stall = i_wb_stall;
            end
            default: ;
        endcase
    end

    assign o_m0_data = i_wb_data;
    assign o_m1_data = i_wb_data;

`ifdef WB_ARB_TIMEOUT_EN
    logic grant_start;
    assign grant_start = (state_d != state_q) && (state_d != ARB_IDLE);

    wishbone_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .grant_start (grant_start),
        .granted     (state_q != ARB_IDLE),
        .bus_active  (o_wb_cyc & o_wb_stb),
        .wb_ack      (i_wb_ack),
        .wb_err      (i_wb_err),
        .timeout     (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wishbone_bus_arbiter.sv
// Self-checking bench for wishbone_bus_arbiter: directed scenarios plus a
// randomized run against an ownership-based reference model.
module tb_wishbone_bus_arbiter;

    typedef struct packed {
        logic        wb_cyc;
        logic        wb_stb;
        logic        wb_we;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [1:0]  stall;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } bus_view_t;

    logic        i_clk;
    logic        i_reset_n;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [9:0]  m_addr [2];
    logic [31:0] m_data [2];
    logic [3:0]  m_sel  [2];
    logic        wb_ack, wb_stall, wb_err;
    logic [31:0] wb_rdata;

    logic        o_m0_ack, o_m0_stall, o_m0_err, o_m1_ack, o_m1_stall, o_m1_err;
    logic [31:0] o_m0_data, o_m1_data, o_wb_data;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [9:0]  o_wb_addr;
    logic [3:0]  o_wb_sel;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus (-1 = nobody) and who won last.
    int owner = -1;
    int last  = 1;

    wishbone_bus_arbiter #(
        .ADDR_WIDTH(10),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_m0_cyc(m_cyc[0]), .i_m0_stb(m_stb[0]), .i_m0_we(m_we[0]),
        .i_m0_addr(m_addr[0]), .i_m0_data(m_data[0]), .i_m0_sel(m_sel[0]),
        .i_m1_cyc(m_cyc[1]), .i_m1_stb(m_stb[1]), .i_m1_we(m_we[1]),
        .i_m1_addr(m_addr[1]), .i_m1_data(m_data[1]), .i_m1_sel(m_sel[1]),
        .o_m0_ack(o_m0_ack), .o_m0_stall(o_m0_stall), .o_m0_err(o_m0_err), .o_m0_data(o_m0_data),
        .o_m1_ack(o_m1_ack), .o_m1_stall(o_m1_stall), .o_m1_err(o_m1_err), .o_m1_data(o_m1_data),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err), .i_wb_data(wb_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic void model_step();
        if (owner < 0) begin
            if (m_cyc == 2'b11)  owner = 1 - last;
            else if (m_cyc[0])   owner = 0;
            else if (m_cyc[1])   owner = 1;
        end else if (!m_cyc[owner[0]]) begin
            owner = m_cyc[~owner[0]] ? 1 - owner : -1;
        end
        if (owner >= 0) last = owner;
    endfunction

    function automatic bus_view_t model_out();
        bus_view_t e;
        e = '0;
        e.stall = 2'b11;
        e.rd0 = wb_rdata;
        e.rd1 = wb_rdata;
        if (owner >= 0) begin
            e.wb_cyc = m_cyc[owner[0]];
            e.wb_stb = m_stb[owner[0]];
            e.wb_we  = m_we[owner[0]];
            e.addr   = m_addr[owner[0]];
            e.data   = m_data[owner[0]];
            e.sel    = m_sel[owner[0]];
            e.ack[owner[0]]   = wb_ack;
            e.err[owner[0]]   = wb_err;
            e.stall[owner[0]] = wb_stall;
        end
        return e;
    endfunction

    function automatic bus_view_t dut_out();
        bus_view_t a;
        a.wb_cyc = o_wb_cyc;
        a.wb_stb = o_wb_stb;
        a.wb_we  = o_wb_we;
        a.addr   = o_wb_addr;
        a.data   = o_wb_data;
        a.sel    = o_wb_sel;
        a.ack    = {o_m1_ack, o_m0_ack};
        a.err    = {o_m1_err, o_m0_err};
        a.stall  = {o_m1_stall, o_m0_stall};
        a.rd0    = o_m0_data;
        a.rd1    = o_m1_data;
        return a;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0;
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = '0; m_data[i] = '0; m_sel[i] = '0;
        end
        wb_ack = 1'b0; wb_stall = 1'b0; wb_err = 1'b0; wb_rdata = '0;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        clear_inputs();
        owner = -1;
        last  = 1;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        clear_inputs();
        m_cyc = 2'b11; m_stb = 2'b11; m_addr[0] = 10'h3FF; wb_ack = 1'b1; wb_err = 1'b1;
        #3;
        checks++;
        if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel} !== '0) begin
            errors++;
            $display("FAIL reset_bus: got cyc=%b stb=%b we=%b addr=%h data=%h sel=%h, expected all 0",
                     o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel);
        end
        checks++;
        if ({o_m1_stall, o_m0_stall, o_m1_ack, o_m0_ack, o_m1_err, o_m0_err} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_resp: got stall=%b%b ack=%b%b err=%b%b, expected stall=11 ack=00 err=00",
                     o_m1_stall, o_m0_stall, o_m1_ack, o_m0_ack, o_m1_err, o_m0_err);
        end
        do_reset();
    endtask

    task automatic test_m0_only();
        do_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 10'h2AA; m_sel[0] = 4'hF;
        #1;
        checks++;
        if (o_wb_cyc !== 1'b0) begin
            errors++; $display("FAIL m0_request_cycle: o_wb_cyc=%b expected 0", o_wb_cyc);
        end
        tick();
        checks++;
        if ({o_wb_cyc, o_wb_stb, o_wb_addr, o_m1_stall} !== {1'b1, 1'b1, 10'h2AA, 1'b1}) begin
            errors++;
            $display("FAIL m0_grant: got cyc=%b stb=%b addr=%h m1_stall=%b, expected 1 1 2aa 1",
                     o_wb_cyc, o_wb_stb, o_wb_addr, o_m1_stall);
        end
        tick();
        tick();
        wb_ack = 1'b1; wb_rdata = 32'h11223344;
        #1;
        checks++;
        if ({o_m0_ack, o_m0_data, o_m1_ack, o_m1_stall} !== {1'b1, 32'h11223344, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL m0_read_ack: got m0_ack=%b m0_data=%h m1_ack=%b m1_stall=%b, expected 1 11223344 0 1",
                     o_m0_ack, o_m0_data, o_m1_ack, o_m1_stall);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        m_cyc = 2'b11; m_stb = 2'b11;
        m_addr[0] = 10'h0AB;
        m_addr[1] = 10'h155; m_we[1] = 1'b1; m_data[1] = 32'hAABBCCDD; m_sel[1] = 4'hF;
        tick();
        checks++;
        if ({o_wb_cyc, o_wb_addr, o_m1_stall, o_m0_stall} !== {1'b1, 10'h0AB, 2'b10}) begin
            errors++;
            $display("FAIL tie_first_m0: got cyc=%b addr=%h stall=%b%b, expected 1 0ab 10",
                     o_wb_cyc, o_wb_addr, o_m1_stall, o_m0_stall);
        end
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
        checks++;
        if ({o_wb_cyc, o_wb_we, o_wb_addr, o_wb_data, o_m0_stall} !== {1'b1, 1'b1, 10'h155, 32'hAABBCCDD, 1'b1}) begin
            errors++;
            $display("FAIL handoff_m1_write: got cyc=%b we=%b addr=%h data=%h m0_stall=%b, expected 1 1 155 aabbccdd 1",
                     o_wb_cyc, o_wb_we, o_wb_addr, o_wb_data, o_m0_stall);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_stall;
        do_reset();
        m_cyc = 2'b11; m_stb = 2'b11;
        m_addr[0] = 10'h010; m_addr[1] = 10'h020;
        tick();
        for (int k = 0; k < 8; k++) begin
            exp_stall = (k % 2 == 0) ? 2'b10 : 2'b01;
            for (int c = 0; c < 2; c++) begin
                checks++;
                if ({o_m1_stall, o_m0_stall} !== exp_stall || o_wb_addr !== m_addr[k % 2]) begin
                    errors++;
                    $display("FAIL round_robin txn %0d cyc %0d: got stall=%b%b addr=%h, expected stall=%b addr=%h",
                             k, c, o_m1_stall, o_m0_stall, o_wb_addr, exp_stall, m_addr[k % 2]);
                end
                if (c == 1) m_cyc[k % 2] = 1'b0;
                tick();
            end
            m_cyc = 2'b11;
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_drop_mid();
        do_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
        wb_ack = 1'b1;
        #1;
        checks++;
        if ({o_m1_ack, o_m0_ack, o_m1_stall, o_m0_stall, o_wb_cyc} !== 5'b00110) begin
            errors++;
            $display("FAIL late_ack_dropped: got ack=%b%b stall=%b%b cyc=%b, expected ack=00 stall=11 cyc=0",
                     o_m1_ack, o_m0_ack, o_m1_stall, o_m0_stall, o_wb_cyc);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_error();
        do_reset();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        tick();
        wb_err = 1'b1;
        #1;
        checks++;
        if ({o_m1_err, o_m0_err} !== 2'b10) begin
            errors++; $display("FAIL err_m1: got err=%b%b expected 10", o_m1_err, o_m0_err);
        end
        wb_ack = 1'b1;
        #1;
        checks++;
        if ({o_m1_ack, o_m1_err, o_m0_ack, o_m0_err} !== 4'b1100) begin
            errors++;
            $display("FAIL ack_and_err: got m1 ack/err=%b%b m0 ack/err=%b%b, expected 11 00",
                     o_m1_ack, o_m1_err, o_m0_ack, o_m0_err);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
        tick();
        checks++;
        if (o_wb_stb !== 1'b1) begin
            errors++; $display("FAIL reset_mid_setup: o_wb_stb=%b expected 1", o_wb_stb);
        end
        #2;
        wb_ack = 1'b1;
        i_reset_n = 1'b0;
        owner = -1; last = 1;
        #1;
        checks++;
        if ({o_wb_cyc, o_wb_stb, o_m1_stall, o_m0_stall, o_m1_ack, o_m0_ack} !== 6'b001100) begin
            errors++;
            $display("FAIL reset_mid_drop: got cyc=%b stb=%b stall=%b%b ack=%b%b, expected 0 0 11 00",
                     o_wb_cyc, o_wb_stb, o_m1_stall, o_m0_stall, o_m1_ack, o_m0_ack);
        end
        m_cyc = '0; m_stb = '0;
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        #1;
        checks++;
        if ({o_m1_ack, o_m0_ack} !== 2'b00) begin
            errors++; $display("FAIL reset_mid_no_ack: got ack=%b%b expected 00", o_m1_ack, o_m0_ack);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        int        since_resp = 0;
        bus_view_t exp_v, act_v;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 3) == 0) m_cyc[i] = ~m_cyc[i];
                m_addr[i] = 10'($urandom);
                m_data[i] = $urandom;
                m_sel[i]  = 4'($urandom_range(0, 15));
            end
            m_stb    = 2'($urandom_range(0, 3));
            m_we     = 2'($urandom_range(0, 3));
            wb_ack   = ($urandom_range(0, 2) == 0) || (since_resp >= 3);
            wb_err   = ($urandom_range(0, 7) == 0);
            wb_stall = 1'($urandom_range(0, 1));
            wb_rdata = $urandom;
            since_resp = (wb_ack || wb_err) ? 0 : since_resp + 1;
            #1;
            exp_v = model_out();
            act_v = dut_out();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL random step %0d (owner %0d): got %h expected %h", n, owner, act_v, exp_v);
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int pulses = 0;
        do_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        for (int t = 0; t < 8; t++) begin
            checks++;
            if ({o_m0_err, o_wb_cyc} !== 2'b01) begin
                errors++;
                $display("FAIL timeout_early cyc %0d: got err=%b cyc=%b expected 0 1", t, o_m0_err, o_wb_cyc);
            end
            tick();
        end
        checks++;
        if ({o_m0_err, o_m1_err, o_wb_cyc} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_pulse: got m0_err=%b m1_err=%b cyc=%b expected 1 0 0", o_m0_err, o_m1_err, o_wb_cyc);
        end
        tick();
        checks++;
        if ({o_m0_err, o_wb_cyc, o_m1_stall, o_m0_stall} !== 4'b0011) begin
            errors++;
            $display("FAIL timeout_idle: got err=%b cyc=%b stall=%b%b expected 0 0 11",
                     o_m0_err, o_wb_cyc, o_m1_stall, o_m0_stall);
        end
        clear_inputs();
        repeat (3) begin
            tick();
            if (o_m0_err) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL timeout_single_pulse: extra err pulses=%0d expected 0", pulses);
        end
    endtask
`endif

    initial begin
        i_reset_n = 1'b0;
        clear_inputs();
        test_reset();
        test_m0_only();
        test_back_to_back();
        test_round_robin();
        test_drop_mid();
        test_error();
        test_reset_mid();
        test_random();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wishbone_bus_arbiter.md
Name: wishbone_bus_arbiter

Overview:
- Shares one Wishbone slave bus (the unified instruction/data memory) between two Wishbone masters: M0 is instruction fetch, M1 is the load/store data master.
- Uses round-robin arbitration with registered grant.
- Grant is held for the whole bus cycle (cyc-level lock), so a burst or read-modify-write is never split.
- Sits between the CPU-side masters and the memory slave in the multi-cycle RISC-V core.

Parameters:
- ADDR_WIDTH, 10, Wishbone word-address width.
- DATA_WIDTH, 32, data bus width; SEL width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, watchdog limit; used only when WB_ARB_TIMEOUT_EN is defined.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_m0_cyc, i_m1_cyc  input  1  master cycle request.
- i_m0_stb, i_m1_stb  input  1  master strobe.
- i_m0_we, i_m1_we  input  1  write enable.
- i_m0_addr, i_m1_addr  input  ADDR_WIDTH  address.
- i_m0_data, i_m1_data  input  DATA_WIDTH  write data.
- i_m0_sel, i_m1_sel  input  DATA_WIDTH/8  byte select.
- o_m0_ack, o_m1_ack  output  1  ack routed to the granted master.
- o_m0_stall, o_m1_stall  output  1  stall to the master.
- o_m0_err, o_m1_err  output  1  error to the master.
- o_m0_data, o_m1_data  output  DATA_WIDTH  read data.
- o_wb_cyc, o_wb_stb, o_wb_we  output  1  slave-side control.
- o_wb_addr  output  ADDR_WIDTH  slave address.
- o_wb_data  output  DATA_WIDTH  slave write data.
- o_wb_sel  output  DATA_WIDTH/8  slave byte select.
- i_wb_ack, i_wb_stall, i_wb_err  input  1  slave responses.
- i_wb_data  input  DATA_WIDTH  slave read data.

Behaviour:
- States:
  - IDLE, GRANT_M0, GRANT_M1: registered, async-cleared to IDLE.
  - last_grant register: reset value M1, so M0 wins the first tie.
- IDLE transitions:
  - Only i_m0_cyc high -> GRANT_M0. Only i_m1_cyc high -> GRANT_M1.
  - Both high -> grant the master that is not last_grant.
  - last_grant updates on entering a GRANT state.
- GRANT_Mx transitions:
  - Stay while i_mx_cyc is high.
  - When i_mx_cyc is low and the other master's cyc is high -> GRANT of the other master directly.
  - When i_mx_cyc is low and the other master's cyc is low -> IDLE.
- Grant latency: one clock from a cyc request to o_wb_cyc high; a cycle running back-to-back from the other master loses no extra idle cycle.
- Slave-side muxing:
  - In GRANT_Mx: o_wb_cyc = i_mx_cyc, and o_wb_stb/we/addr/data/sel = master x inputs.
  - In IDLE: o_wb_cyc = o_wb_stb = o_wb_we = 0; addr/data/sel = 0.
- Master-side responses:
  - Granted master: ack/err/stall = i_wb_ack/i_wb_err/i_wb_stall, combinationally.
  - Non-granted master: ack = 0, err = 0, stall = 1.
  - o_mx_data = i_wb_data for both masters; valid only with ack.
- Reset values: state IDLE; o_wb_cyc/stb/we = 0; addr/data/sel = 0; all acks/errs = 0; both stalls = 1.
- Reset mid-cycle: the bus is dropped immediately (async) and any outstanding slave ack is ignored.
- Master dropping cyc mid-transaction: the grant is released at the next edge and a late i_wb_ack is not routed to anyone.
- i_wb_ack and i_wb_err in the same cycle: forward both. The master treats err as dominant.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on grant entry and on every i_wb_ack/i_wb_err.
  - It increments each cycle o_wb_cyc & o_wb_stb is high.
  - On reaching TIMEOUT_CYCLES: pulse o_mx_err for the granted master for exactly 1 cycle, force o_wb_cyc = 0 in that cycle, then go to IDLE.
  - The master must drop cyc after err; re-request is re-arbitrated normally.
- Undefined: no counter and no timeout; the grant is held indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package wishbone_pkg:
  - state encoding localparams (ARB_IDLE = 2'd0, ARB_GRANT_M0 = 2'd1, ARB_GRANT_M1 = 2'd2);
  - master index constants;
  - default ADDR_WIDTH/DATA_WIDTH.
- Sub-module wishbone_arb_timeout (counter plus compare), instantiated only under WB_ARB_TIMEOUT_EN.

Test Plan:
- M0 only: i_m0_cyc = stb = 1, addr 10'h2AA, we = 0; slave acks with 32'h11223344 on the 3rd cycle -> o_wb_cyc is high 1 clock after request, o_m0_ack = 1 with o_m0_data = 32'h11223344, o_m1_stall = 1 throughout.
- Simultaneous request after reset, both cyc = 1 -> M0 is granted first. M0 drops cyc -> GRANT_M1 on the next edge with no idle cycle; M1 writes 32'hAABBCCDD to 10'h155 and o_wb_data matches.
- Round-robin fairness: both masters request continuously, each holding cyc 2 cycles -> grants alternate M0, M1, M0, M1 over 8 transactions.
- Reset mid-cycle: i_reset_n low while GRANT_M1 and o_wb_stb = 1 -> o_wb_cyc = 0 and both stalls = 1 in the same cycle, with no ack routed afterward.
- Error forwarding: slave asserts i_wb_err on an M1 access -> o_m1_err = 1 and o_m0_err = 0.
- WB_ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 8: slave never acks -> o_m0_err pulses exactly once 8 cycles after the strobe, o_wb_cyc = 0, state returns to IDLE.
